// File: rtl/nn_batch_sequencer_if.sv
// Host/loader and Neural_network signal bundle for nn_batch_sequencer.
// The slave modport is the sequencer's view; master is the environment's.
interface nn_batch_sequencer_if #(
  parameter int unsigned N_IN  = 6,
  parameter int unsigned N_OUT = 3,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW = $clog2(DEPTH + 1);

  // loader side
  logic                  ld_valid_x70;
  logic [AW-1:0]         ld_addr_x70;
  logic [N_IN*DW-1:0]    ld_data_x70;
  logic                  ld_ready_x70;

  // batch control
  logic                  run_x70;
  logic [NW-1:0]         num_vec_x70;
  logic                  busy_x70;
  logic                  batch_done_x70;
  logic                  timeout_x70;

  // Neural_network handshake
  logic [N_IN*DW-1:0]    nn_x_x70;
  logic                  nn_start_x70;
  logic                  nn_done_x70;
  logic [N_OUT*DW-1:0]   nn_y_x70;

  // result readback
  logic [AW-1:0]         rd_addr_x70;
  logic [N_OUT*DW-1:0]   rd_y_x70;
  logic [CNT_W-1:0]      rd_cyc_x70;

  modport slave (
    input  ld_valid_x70, ld_addr_x70, ld_data_x70,
    output ld_ready_x70,
    input  run_x70, num_vec_x70,
    output busy_x70, batch_done_x70, timeout_x70,
    output nn_x_x70, nn_start_x70,
    input  nn_done_x70, nn_y_x70,
    input  rd_addr_x70,
    output rd_y_x70, rd_cyc_x70
  );

  modport master (
    output ld_valid_x70, ld_addr_x70, ld_data_x70,
    input  ld_ready_x70,
    output run_x70, num_vec_x70,
    input  busy_x70, batch_done_x70, timeout_x70,
    input  nn_x_x70, nn_start_x70,
    output nn_done_x70, nn_y_x70,
    output rd_addr_x70,
    input  rd_y_x70, rd_cyc_x70
  );
endinterface

// File: rtl/nn_batch_sequencer.sv
// Batch driver for the Neural_network core: runs up to DEPTH buffered input
// vectors back-to-back through the start/done handshake, storing N_OUT output
// words and a start-to-done cycle count per vector, with a per-vector timeout.
module nn_batch_sequencer #(
  parameter int unsigned N_IN    = 6,
  parameter int unsigned N_OUT   = 3,
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic               clk_x70,
  input  logic               rst_n_x70,
  nn_batch_sequencer_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW = $clog2(DEPTH + 1);
  localparam int unsigned VW = N_IN * DW;
  localparam int unsigned YW = N_OUT * DW;
  localparam logic [DW-1:0]    QNAN    = DW'(32'h7FC00000);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_START, S_WAIT, S_STORE, S_FINISH
  } state_t;

  state_t state, state_nx;

  logic [VW-1:0]    vec_buf [DEPTH];
  logic [YW-1:0]    res_y   [DEPTH];
  logic [CNT_W-1:0] res_cyc [DEPTH];

  logic [NW-1:0]    n_vec;
  logic [AW-1:0]    idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             done_q;
  logic [YW-1:0]    y_lat;
  logic [CNT_W-1:0] cyc_lat;
  logic             tmo_flag;
  logic [VW-1:0]    nn_x;
  logic [YW-1:0]    rd_y;
  logic [CNT_W-1:0] rd_cyc;

  logic             done_rise;
  logic             tmo_hit;
  logic             last_vec;
  logic [NW-1:0]    num_clip;
  logic [YW-1:0]    nan_y;

  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  // Only a fresh rising edge counts, so a done left high from a previous
  // vector cannot complete the current one.
  assign done_rise = bus.nn_done_x70 && !done_q;
  assign tmo_hit   = (cnt_inc >= TMO);
  assign last_vec  = ((NW'(idx) + NW'(1)) == n_vec);
  assign num_clip  = (bus.num_vec_x70 > NW'(DEPTH)) ? NW'(DEPTH) : bus.num_vec_x70;
  assign nan_y     = {N_OUT{QNAN}};

  assign bus.ld_ready_x70   = (state == S_IDLE);
  assign bus.busy_x70       = (state == S_DRIVE) || (state == S_START) ||
                              (state == S_WAIT)  || (state == S_STORE);
  assign bus.batch_done_x70 = (state == S_FINISH);
  assign bus.nn_start_x70   = (state == S_START);
  assign bus.timeout_x70    = tmo_flag;
  assign bus.nn_x_x70       = nn_x;
  assign bus.rd_y_x70       = rd_y;
  assign bus.rd_cyc_x70     = rd_cyc;

  // State register
  always_ff @(posedge clk_x70) begin
    if (!rst_n_x70) state <= S_IDLE;
    else            state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (bus.run_x70) state_nx = (num_clip == '0) ? S_FINISH : S_DRIVE;
      S_DRIVE:  state_nx = S_START;
      S_START:  state_nx = S_WAIT;
      S_WAIT:   if (done_rise || tmo_hit) state_nx = S_STORE;
      S_STORE:  state_nx = last_vec ? S_FINISH : S_DRIVE;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Batch datapath: vector index, cycle counter, result latch, readback regs
  always_ff @(posedge clk_x70) begin
    if (!rst_n_x70) begin
      n_vec    <= '0;
      idx      <= '0;
      cnt      <= '0;
      done_q   <= 1'b0;
      y_lat    <= '0;
      cyc_lat  <= '0;
      tmo_flag <= 1'b0;
      nn_x     <= '0;
      rd_y     <= '0;
      rd_cyc   <= '0;
    end else begin
      done_q <= bus.nn_done_x70;
      rd_y   <= res_y[bus.rd_addr_x70];
      rd_cyc <= res_cyc[bus.rd_addr_x70];
      case (state)
        S_IDLE: begin
          if (bus.run_x70) begin
            n_vec    <= num_clip;
            idx      <= '0;
            tmo_flag <= 1'b0;
          end
        end
        S_DRIVE: nn_x <= vec_buf[idx];
        S_START: cnt  <= '0;
        S_WAIT: begin
          cnt <= cnt_inc;
          if (done_rise) begin
            y_lat   <= bus.nn_y_x70;
            cyc_lat <= cnt_inc;
          end else if (tmo_hit) begin
            y_lat    <= nan_y;
            cyc_lat  <= TMO;
            tmo_flag <= 1'b1;
          end
        end
        S_STORE: if (!last_vec) idx <= idx + AW'(1);
        default: ;
      endcase
    end
  end

  // Vector and result buffers: not cleared by reset, no writes while in reset
  always_ff @(posedge clk_x70) begin
    if (rst_n_x70) begin
      if ((state == S_IDLE) && bus.ld_valid_x70)
        vec_buf[bus.ld_addr_x70] <= bus.ld_data_x70;
      if (state == S_STORE) begin
        res_y[idx]   <= y_lat;
        res_cyc[idx] <= cyc_lat;
      end
    end
  end
endmodule

// File: tb/tb_nn_batch_sequencer.sv
// Directed bench for nn_batch_sequencer with a small Neural_network BFM.
module tb_nn_batch_sequencer;
  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nn_batch_sequencer_if #(.N_IN(6), .N_OUT(3), .DW(32), .DEPTH(DEPTH), .CNT_W(16)) bus ();

  nn_batch_sequencer #(
    .N_IN(6), .N_OUT(3), .DW(32), .DEPTH(DEPTH), .CNT_W(16), .TIMEOUT(64)
  ) dut (
    .clk_x70  (clk),
    .rst_n_x70(rst_n),
    .bus      (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // BFM: mode 0 pulses done 10 cycles after start with y = input words 2..4;
  // mode 1 same but never answers the start numbered skip_at;
  // mode 2 holds done high (arm_high) across start, drops it 3 cycles later
  // and raises it again 5 cycles after that.
  int unsigned bfm_mode = 0;
  int unsigned skip_at  = 0;
  bit          arm_high = 0;
  int unsigned start_cnt = 0;
  int unsigned bd_cnt    = 0;
  bit          active    = 0;
  int unsigned ticks     = 0;
  logic [95:0] bfm_y     = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0;
      bus.nn_done_x70 = 1'b0;
    end else begin
      if (bus.batch_done_x70) bd_cnt++;
      if (active) begin
        ticks++;
        if (bfm_mode == 2) begin
          if (ticks == 3) bus.nn_done_x70 = 1'b0;
          else if (ticks == 8) begin
            bus.nn_done_x70 = 1'b1;
            bus.nn_y_x70 = bfm_y;
            active = 0;
          end
        end else begin
          if (ticks == 10) begin
            bus.nn_done_x70 = 1'b1;
            bus.nn_y_x70 = bfm_y;
          end else if (ticks == 11) begin
            bus.nn_done_x70 = 1'b0;
            active = 0;
          end
        end
      end else begin
        bus.nn_done_x70 = (bfm_mode == 2) && arm_high;
      end
      if (bus.nn_start_x70) begin
        if (!(bfm_mode == 1 && start_cnt == skip_at)) begin
          active = 1;
          ticks = 0;
          bfm_y = bus.nn_x_x70[64 +: 96];
        end
        start_cnt++;
      end
    end
  end

  logic [191:0] vecs [DEPTH];

  task automatic load_vec(input int unsigned a, input logic [191:0] d);
    bus.ld_valid_x70 = 1'b1;
    bus.ld_addr_x70  = 5'(a);
    bus.ld_data_x70  = d;
    @(negedge clk);
    bus.ld_valid_x70 = 1'b0;
  endtask

  task automatic run_batch(input int unsigned num);
    bus.run_x70     = 1'b1;
    bus.num_vec_x70 = 6'(num);
    @(negedge clk);
    bus.run_x70 = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    bit seen = 0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.batch_done_x70) seen = 1;
    end
    check_eq(tag, 128'(seen), 128'(1));
  endtask

  task automatic read_res(input int unsigned a, output logic [95:0] y, output logic [15:0] c);
    bus.rd_addr_x70 = 5'(a);
    @(negedge clk);
    y = bus.rd_y_x70;
    c = bus.rd_cyc_x70;
  endtask

  task automatic check_res(input string tag, input int unsigned a,
                           input logic [95:0] ey, input logic [15:0] ec);
    logic [95:0] y;
    logic [15:0] c;
    read_res(a, y, c);
    check_eq($sformatf("%s_y%0d", tag, a), 128'(y), 128'(ey));
    check_eq($sformatf("%s_cyc%0d", tag, a), 128'(c), 128'(ec));
  endtask

  initial begin
    int unsigned s0, b0;
    logic [95:0] ry;
    logic [15:0] rc;
    bit seen;

    rst_n = 1'b0;
    bus.ld_valid_x70 = 1'b0; bus.ld_addr_x70 = '0; bus.ld_data_x70 = '0;
    bus.run_x70 = 1'b0; bus.num_vec_x70 = '0; bus.rd_addr_x70 = '0;
    bus.nn_y_x70 = '0;

    vecs[0] = {32'hBD292A30, 32'hBD2B9F56, 32'hBBF9096C, 32'h3A83126F, 32'h00000000, 32'h00000000};
    vecs[1] = {32'h00000001, 32'h3DCCCCCD, 32'hBF000000, 32'h40490FDB, 32'hC0000000, 32'h3F800000};
    vecs[2] = {32'h12345678, 32'h7F7FFFFF, 32'h80000000, 32'hFF800000, 32'h00800000, 32'hDEADBEEF};

    repeat (3) @(negedge clk);
    // reset state
    check_eq("rst_ld_ready",   128'(bus.ld_ready_x70),   128'(1));
    check_eq("rst_busy",       128'(bus.busy_x70),       128'(0));
    check_eq("rst_nn_start",   128'(bus.nn_start_x70),   128'(0));
    check_eq("rst_batch_done", 128'(bus.batch_done_x70), 128'(0));
    check_eq("rst_timeout",    128'(bus.timeout_x70),    128'(0));
    check_eq("rst_nn_x",       128'(bus.nn_x_x70),       128'(0));
    check_eq("rst_rd_y",       128'(bus.rd_y_x70),       128'(0));
    check_eq("rst_rd_cyc",     128'(bus.rd_cyc_x70),     128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: three vectors, done 10 cycles after each start
    for (int unsigned i = 0; i < 3; i++) load_vec(i, vecs[i]);
    s0 = start_cnt; b0 = bd_cnt;
    bus.run_x70 = 1'b1; bus.num_vec_x70 = 6'd3;
    @(negedge clk);
    bus.run_x70 = 1'b0;
    check_eq("t1_busy_after_run", 128'(bus.busy_x70),     128'(1));
    check_eq("t1_ld_ready_busy",  128'(bus.ld_ready_x70), 128'(0));
    check_eq("t1_no_start_yet",   128'(bus.nn_start_x70), 128'(0));
    @(negedge clk);
    check_eq("t1_first_start",    128'(bus.nn_start_x70), 128'(1));
    check_eq("t1_first_nn_x",     128'(bus.nn_x_x70),     128'(vecs[0]));
    wait_done("t1_done", 200);
    repeat (5) @(negedge clk);
    check_eq("t1_starts",     128'(start_cnt - s0), 128'(3));
    check_eq("t1_batch_done", 128'(bd_cnt - b0),    128'(1));
    check_eq("t1_timeout",    128'(bus.timeout_x70), 128'(0));
    check_eq("t1_busy_end",   128'(bus.busy_x70),    128'(0));
    for (int unsigned i = 0; i < 3; i++) check_res("t1", i, vecs[i][159:64], 16'd10);

    // 2: zero-length batch
    s0 = start_cnt;
    bus.run_x70 = 1'b1; bus.num_vec_x70 = 6'd0;
    @(negedge clk);
    bus.run_x70 = 1'b0;
    check_eq("t2_batch_done", 128'(bus.batch_done_x70), 128'(1));
    check_eq("t2_busy",       128'(bus.busy_x70),       128'(0));
    check_eq("t2_ld_ready",   128'(bus.ld_ready_x70),   128'(0));
    @(negedge clk);
    check_eq("t2_done_pulse", 128'(bus.batch_done_x70), 128'(0));
    check_eq("t2_busy2",      128'(bus.busy_x70),       128'(0));
    repeat (3) @(negedge clk);
    check_eq("t2_starts",     128'(start_cnt - s0),     128'(0));

    // 3: vector 1 of 3 never completes
    bfm_mode = 1; skip_at = start_cnt + 1; s0 = start_cnt;
    run_batch(3);
    wait_done("t3_done", 400);
    repeat (3) @(negedge clk);
    check_eq("t3_starts",  128'(start_cnt - s0),   128'(3));
    check_eq("t3_timeout", 128'(bus.timeout_x70),  128'(1));
    check_res("t3", 0, vecs[0][159:64], 16'd10);
    check_res("t3", 1, {3{32'h7FC00000}}, 16'd64);
    check_res("t3", 2, vecs[2][159:64], 16'd10);
    bfm_mode = 0;

    // 4: done held high across start; only the later rise completes
    bfm_mode = 2; arm_high = 1;
    repeat (2) @(negedge clk);
    run_batch(1);
    wait_done("t4_done", 100);
    check_eq("t4_timeout_cleared", 128'(bus.timeout_x70), 128'(0));
    check_res("t4", 0, vecs[0][159:64], 16'd8);
    arm_high = 0;
    @(negedge clk);
    bfm_mode = 0;
    repeat (2) @(negedge clk);

    // 5: reset in the middle of WAIT
    s0 = start_cnt;
    run_batch(1);
    seen = 0;
    for (int unsigned i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.nn_start_x70) seen = 1;
    end
    check_eq("t5_start_seen", 128'(seen), 128'(1));
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t5_nn_start", 128'(bus.nn_start_x70), 128'(0));
    check_eq("t5_busy",     128'(bus.busy_x70),     128'(0));
    check_eq("t5_timeout",  128'(bus.timeout_x70),  128'(0));
    check_eq("t5_ld_ready", 128'(bus.ld_ready_x70), 128'(1));
    check_eq("t5_rd_cyc",   128'(bus.rd_cyc_x70),   128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_res("t5_kept", 0, vecs[0][159:64], 16'd8);
    repeat (15) @(negedge clk);
    check_eq("t5_no_restart", 128'(start_cnt - s0), 128'(1));
    run_batch(1);
    wait_done("t5_fresh_done", 100);
    check_res("t5_fresh", 0, vecs[0][159:64], 16'd10);

    // 6: num_vec above DEPTH; run/ld_valid during busy ignored
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned w = 0; w < 6; w++) vecs[i][w*32 +: 32] = 32'hA5A50000 ^ 32'(i * 16 + w);
      load_vec(i, vecs[i]);
    end
    s0 = start_cnt; b0 = bd_cnt;
    run_batch(40);
    repeat (5) @(negedge clk);
    check_eq("t6_busy", 128'(bus.busy_x70), 128'(1));
    bus.ld_valid_x70 = 1'b1; bus.ld_addr_x70 = 5'd0; bus.ld_data_x70 = '1;
    bus.run_x70 = 1'b1; bus.num_vec_x70 = 6'd1;
    @(negedge clk);
    bus.ld_valid_x70 = 1'b0; bus.run_x70 = 1'b0;
    wait_done("t6_done", 1000);
    repeat (20) @(negedge clk);
    check_eq("t6_starts",     128'(start_cnt - s0), 128'(32));
    check_eq("t6_batch_done", 128'(bd_cnt - b0),    128'(1));
    check_eq("t6_idle",       128'(bus.ld_ready_x70), 128'(1));
    check_res("t6", 0,  vecs[0][159:64],  16'd10);
    check_res("t6", 5,  vecs[5][159:64],  16'd10);
    check_res("t6", 31, vecs[31][159:64], 16'd10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
